// File: rtl/memory_pkg.sv
// Memory access size codes (funct3 encoding) shared by the decoder and the LSU.
package memory_pkg;

  typedef logic [2:0] ldst_size_t;

  localparam ldst_size_t LDST_B  = 3'd0;
  localparam ldst_size_t LDST_H  = 3'd1;
  localparam ldst_size_t LDST_W  = 3'd2;
  localparam ldst_size_t LDST_BU = 3'd4;
  localparam ldst_size_t LDST_HU = 3'd5;

  // Unsigned codes only make sense for loads; a store with BU/HU is illegal.
  function automatic logic size_is_legal(input ldst_size_t size, input logic we);
    case (size)
      LDST_B, LDST_H, LDST_W: size_is_legal = 1'b1;
      LDST_BU, LDST_HU:       size_is_legal = ~we;
      default:                size_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_load_align.sv
// Combinational load data extraction: selects the addressed byte/halfword lane
// and sign- or zero-extends it to 32 bits.
module riscv_lsu_load_align
  import memory_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [1:0]  offset_i,
  input  ldst_size_t  size_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = rd_word_i[8*offset_i +: 8];
    half_v   = offset_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    result_o = 32'h0;
    case (size_i)
      LDST_B:  result_o = {{24{byte_v[7]}}, byte_v};
      LDST_BU: result_o = {24'h0, byte_v};
      LDST_H:  result_o = {{16{half_v[15]}}, half_v};
      LDST_HU: result_o = {16'h0, half_v};
      LDST_W:  result_o = rd_word_i;
      default: result_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: error screening, byte-enable/lane generation and core stall.
//   state        | meaning
//   IDLE (q=0)   | no access outstanding; a new legal request stalls the core
//   WAIT (q=1)   | request issued; stall released on the cycle mem_ready_i=1
module riscv_lsu
  import memory_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]  stall_q, stall_d;
  logic        misaligned;
  logic [31:0] align_res;

  always_comb begin
    misaligned = 1'b0;
    case (core_size_i)
      LDST_H, LDST_HU: misaligned = core_addr_i[0];
      LDST_W:          misaligned = |core_addr_i[1:0];
      default:         misaligned = 1'b0;
    endcase
  end

  // Errors are masked in reset so every core-facing flag reads 0 there.
  assign core_err_o = core_req_i & ~rst_i &
                      (~size_is_legal(core_size_i, core_we_i) | misaligned);
  assign mem_req_o  = core_req_i & ~core_err_o & ~rst_i;
  assign mem_we_o   = core_we_i & mem_req_o;
  assign mem_addr_o = core_addr_i;

  always_comb begin
    mem_be_o = 4'b0000;
    mem_wd_o = core_wd_i;
    case (core_size_i)
      LDST_B, LDST_BU: begin
        mem_be_o = 4'b0001 << core_addr_i[1:0];
        mem_wd_o = {4{core_wd_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        mem_be_o = core_addr_i[1] ? 4'b1100 : 4'b0011;
        mem_wd_o = {2{core_wd_i[15:0]}};
      end
      LDST_W:  mem_be_o = 4'b1111;
      default: mem_be_o = 4'b0000;
    endcase
    if (!mem_req_o) mem_be_o = 4'b0000;
  end

  riscv_lsu_load_align u_load_align (
    .rd_word_i (mem_rd_i),
    .offset_i  (core_addr_i[1:0]),
    .size_i    (core_size_i),
    .result_o  (align_res)
  );

  assign core_rd_o = (mem_req_o & ~core_we_i) ? align_res : 32'h0;

  assign core_stall_o = mem_req_o & ~((stall_q == S_WAIT) & mem_ready_i);
  assign stall_d      = core_stall_o ? S_WAIT : S_IDLE;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_q <= S_IDLE;
    else       stall_q <= stall_d;
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with a behavioural word memory and a load-data scoreboard.
module tb_riscv_lsu;
  import memory_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o, core_err_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb_q[$];
  logic [31:0] mem [0:63];

  always #5 clk_i = ~clk_i;

  riscv_lsu dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
    .core_stall_o(core_stall_o), .core_err_o(core_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
  );

  // Word memory: writes commit on the completing edge, read data lags one cycle.
  always @(posedge clk_i) begin
    if (mem_req_o && mem_we_o && mem_ready_i)
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) mem[mem_addr_o[7:2]][8*b +: 8] <= mem_wd_o[8*b +: 8];
    mem_rd_i <= mem[mem_addr_o[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access, inputs applied just after a posedge; returns once the core is released.
  task automatic access(input string tag, input logic we, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd, input int delay,
                        input logic [3:0] exp_be, input logic [31:0] exp_val);
    int cyc;
    bit done;
    logic [31:0] exp_rd;
    if (!we) sb_q.push_back(exp_val);
    core_req_i = 1'b1; core_we_i = we; core_size_i = sz;
    core_addr_i = addr; core_wd_i = wd;
    mem_ready_i = (delay == 0);
    cyc = 0; done = 0;
    while (!done && cyc < 20) begin
      @(negedge clk_i);
      if (cyc == 0) begin
        chk({tag, "_req"}, {31'h0, mem_req_o}, 32'h1);
        chk({tag, "_addr"}, mem_addr_o, addr);
        chk({tag, "_be"}, {28'h0, mem_be_o}, {28'h0, exp_be});
        if (we) chk({tag, "_wd"}, mem_wd_o, exp_val);
      end
      if (!core_stall_o) done = 1;
      else begin
        @(posedge clk_i); #1;
        cyc++;
        mem_ready_i = (cyc > delay);
      end
    end
    chk({tag, "_done"}, {31'h0, done}, 32'h1);
    chk({tag, "_stall_cycles"}, cyc, delay + 1);
    if (!we && sb_q.size() > 0) begin
      exp_rd = sb_q.pop_front();
      if (done) chk({tag, "_rd"}, core_rd_o, exp_rd);
    end
    @(posedge clk_i); #1;
    core_req_i = 1'b0; mem_ready_i = 1'b1;
  endtask

  task automatic err_case(input string tag, input logic we, input logic [2:0] sz,
                          input logic [31:0] addr);
    core_req_i = 1'b1; core_we_i = we; core_size_i = sz;
    core_addr_i = addr; core_wd_i = 32'hA5A5A5A5;
    @(negedge clk_i);
    chk({tag, "_err"}, {31'h0, core_err_o}, 32'h1);
    chk({tag, "_req"}, {31'h0, mem_req_o}, 32'h0);
    chk({tag, "_stall"}, {31'h0, core_stall_o}, 32'h0);
    @(posedge clk_i); #1;
    core_req_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst_i = 1'b1; mem_ready_i = 1'b1;
    core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = LDST_W;
    core_addr_i = 32'h10; core_wd_i = 32'h11111111;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_we", {31'h0, mem_we_o}, 32'h0);
    chk("rst_be", {28'h0, mem_be_o}, 32'h0);
    chk("rst_stall", {31'h0, core_stall_o}, 32'h0);
    chk("rst_err", {31'h0, core_err_o}, 32'h0);
    chk("rst_rd", core_rd_o, 32'h0);
    core_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    access("sw10", 1'b1, LDST_W, 32'h10, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF);
    access("lw10", 1'b0, LDST_W, 32'h10, 32'h0, 0, 4'b1111, 32'hDEADBEEF);

    access("sw20", 1'b1, LDST_W, 32'h20, 32'h80FF7F01, 0, 4'b1111, 32'h80FF7F01);
    access("lb23", 1'b0, LDST_B, 32'h23, 32'h0, 0, 4'b1000, 32'hFFFFFF80);
    access("lbu23", 1'b0, LDST_BU, 32'h23, 32'h0, 0, 4'b1000, 32'h00000080);
    access("lb21", 1'b0, LDST_B, 32'h21, 32'h0, 0, 4'b0010, 32'h0000007F);
    access("lh22", 1'b0, LDST_H, 32'h22, 32'h0, 0, 4'b1100, 32'hFFFF80FF);
    access("lhu20", 1'b0, LDST_HU, 32'h20, 32'h0, 0, 4'b0011, 32'h00007F01);

    access("sw30", 1'b1, LDST_W, 32'h30, 32'hAAAA5555, 0, 4'b1111, 32'hAAAA5555);
    access("sh32", 1'b1, LDST_H, 32'h32, 32'hFFFF1234, 0, 4'b1100, 32'h12341234);
    access("lw30a", 1'b0, LDST_W, 32'h30, 32'h0, 0, 4'b1111, 32'h12345555);
    access("sb31", 1'b1, LDST_B, 32'h31, 32'h000000CD, 0, 4'b0010, 32'hCDCDCDCD);
    access("lw30b", 1'b0, LDST_W, 32'h30, 32'h0, 0, 4'b1111, 32'h1234CD55);

    err_case("lw41", 1'b0, LDST_W, 32'h41);
    err_case("lh43", 1'b0, LDST_H, 32'h43);
    err_case("sz3", 1'b0, 3'd3, 32'h40);
    err_case("sz7", 1'b0, 3'd7, 32'h40);
    err_case("sb_bu", 1'b1, LDST_BU, 32'h40);
    err_case("sw42", 1'b1, LDST_W, 32'h42);

    access("lw_wait", 1'b0, LDST_W, 32'h10, 32'h0, 3, 4'b1111, 32'hDEADBEEF);

    // Async reset during WAIT: outputs must drop before any clock edge.
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = LDST_W;
    core_addr_i = 32'h20; mem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("mid_stall_pre", {31'h0, core_stall_o}, 32'h1);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_stall", {31'h0, core_stall_o}, 32'h0);
    chk("mid_req", {31'h0, mem_req_o}, 32'h0);
    core_req_i = 1'b0; mem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    access("lw_post", 1'b0, LDST_W, 32'h20, 32'h0, 0, 4'b1111, 32'h80FF7F01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
